// File: rtl/decoder_nto2n_seq.sv
// N-to-2**N one-hot decoder with registered output and an optional timed scan mode.
// Scan mode (IDLE/SCAN FSM, dwell and step counters) is built only when DEC_SCAN_EN is defined.
module decoder_nto2n_seq #(
    parameter int unsigned N     = 2,
    parameter int unsigned DWELL = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               mode,
    input  logic               in_valid,
    input  logic [N-1:0]       in_code,
    output logic               in_ready,
    output logic [0:(2**N)-1]  d,
    output logic               out_valid,
    output logic               done
);

    localparam int unsigned W = 2 ** N;

    logic [0:W-1] d_q, d_d;
    logic         out_valid_q, out_valid_d;
    logic [0:W-1] code_onehot;
    logic         accept;

    always_comb begin
        code_onehot          = '0;
        code_onehot[in_code] = 1'b1;
    end

    assign d         = d_q;
    assign out_valid = out_valid_q;

`ifdef DEC_SCAN_EN

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    localparam logic [7:0]   DwellLast = 8'(DWELL - 1);
    localparam logic [N-1:0] StepLast  = '1;

    state_e       state_q, state_d;
    logic [7:0]   dwell_q, dwell_d;
    logic [N-1:0] step_q, step_d;
    logic         done_q, done_d;
    logic [0:W-1] d_rot;

    // Advance the selected index by one, wrapping the last code back to 0.
    assign d_rot    = {d_q[W-1], d_q[0:W-2]};
    assign in_ready = en && (state_q == StIdle);
    assign accept   = in_valid && in_ready;
    assign done     = done_q;

    always_comb begin
        state_d     = state_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        dwell_d     = dwell_q;
        step_d      = step_q;
        done_d      = 1'b0;
        if (en) begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        d_d         = code_onehot;
                        out_valid_d = 1'b1;
                        dwell_d     = '0;
                        step_d      = '0;
                        if (mode) begin
                            state_d = StScan;
                        end
                    end
                end
                StScan: begin
                    if (dwell_q == DwellLast) begin
                        dwell_d = '0;
                        if (step_q == StepLast) begin
                            d_d         = '0;
                            out_valid_d = 1'b0;
                            done_d      = 1'b1;
                            step_d      = '0;
                            state_d     = StIdle;
                        end else begin
                            d_d    = d_rot;
                            step_d = step_q + 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q + 8'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            d_q         <= '0;
            out_valid_q <= 1'b0;
            dwell_q     <= '0;
            step_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
            dwell_q     <= dwell_d;
            step_q      <= step_d;
            done_q      <= done_d;
        end
    end

`else

    // Without scan support the mode input and dwell setting have no effect.
    localparam int unsigned unused_dwell = DWELL;
    logic unused_mode;

    assign unused_mode = mode;
    assign in_ready    = en;
    assign accept      = in_valid && in_ready;
    assign done        = 1'b0;

    always_comb begin
        d_d         = d_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            d_d         = code_onehot;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
        end
    end

`endif

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Scoreboard bench for decoder_nto2n_seq: directed scenarios followed by random traffic.
// Tests the scan build (N=2) when DEC_SCAN_EN is defined, otherwise the direct-only build (N=3).
module tb_decoder_nto2n_seq;

`ifdef DEC_SCAN_EN
    localparam int N      = 2;
    localparam bit ScanEn = 1'b1;
`else
    localparam int N      = 3;
    localparam bit ScanEn = 1'b0;
`endif
    localparam int DWELL = 2;
    localparam int W     = 2 ** N;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         mode;
    logic         in_valid;
    logic [N-1:0] in_code;
    logic         in_ready;
    logic [0:W-1] d;
    logic         out_valid;
    logic         done;

    decoder_nto2n_seq #(
        .N     (N),
        .DWELL (DWELL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_code   (in_code),
        .in_ready  (in_ready),
        .d         (d),
        .out_valid (out_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:W-1] d;
        logic         ov;
        logic         done;
        logic         rdy;
    } snap_t;

    snap_t exp_q[$];
    int    checks = 0;
    int    passed = 0;
    int    cyc    = 0;
    bit    finished = 1'b0;

    // Reference model: scan described as elapsed time since the start code.
    int m_idx;
    bit m_ov;
    bit m_done;
    bit m_scan;
    int m_start;
    int m_t;

    function automatic snap_t model_snap(input logic cur_en);
        snap_t s;
        s.d = '0;
        if (m_idx >= 0) s.d[m_idx] = 1'b1;
        s.ov   = m_ov;
        s.done = m_done;
        s.rdy  = cur_en && !m_scan;
        return s;
    endfunction

    task automatic model_reset();
        m_idx  = -1;
        m_ov   = 1'b0;
        m_done = 1'b0;
        m_scan = 1'b0;
        m_start = 0;
        m_t    = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (en) begin
            m_done = 1'b0;
            if (m_scan) begin
                m_t = m_t + 1;
                if (m_t == W * DWELL) begin
                    m_scan = 1'b0;
                    m_ov   = 1'b0;
                    m_idx  = -1;
                    m_done = 1'b1;
                end else begin
                    m_idx = (m_start + m_t / DWELL) % W;
                end
            end else if (in_valid) begin
                m_idx = int'(in_code);
                m_ov  = 1'b1;
                if (ScanEn && mode) begin
                    m_scan  = 1'b1;
                    m_start = int'(in_code);
                    m_t     = 0;
                end
            end
        end else begin
            m_done = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, record what the DUT must show before the next edge.
    task automatic cycle(input logic r, input logic e, input logic m, input logic v,
                         input int c);
        logic [31:0] cv;
        cv       = c;
        rst      = r;
        en       = e;
        mode     = m;
        in_valid = v;
        in_code  = cv[N-1:0];
        exp_q.push_back(model_snap(e));
        model_step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        snap_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (d === e.d && out_valid === e.ov && done === e.done && in_ready === e.rdy) begin
                passed++;
            end else begin
                $display("FAIL outputs @cyc%0d: got d=%b out_valid=%b done=%b in_ready=%b, want d=%b out_valid=%b done=%b in_ready=%b",
                         cyc, d, out_valid, done, in_ready, e.d, e.ov, e.done, e.rdy);
            end
            cyc++;
        end
    end

    initial begin
        #100000;
        if (!finished) begin
            $display("FAIL timeout: stimulus did not complete within the wait limit");
            $finish;
        end
    end

    initial begin
        rst      = 1'b1;
        en       = 1'b1;
        mode     = 1'b0;
        in_valid = 1'b0;
        in_code  = '0;
        @(posedge clk);
        #1;
        model_reset();

        checks++;
        if (d === '0 && out_valid === 1'b0 && done === 1'b0 && in_ready === 1'b1) begin
            passed++;
        end else begin
            $display("FAIL reset state: got d=%b out_valid=%b done=%b in_ready=%b",
                     d, out_valid, done, in_ready);
        end

        cycle(1, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);

        // Direct decode on consecutive cycles, then hold.
        for (int c = 0; c < 4; c++) cycle(0, 1, 0, 1, c);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);

        // Scan from 2 with wrap; a pending request waits for the return to idle.
        cycle(0, 1, 1, 1, 2);
        for (int i = 0; i < 11; i++) cycle(0, 1, 0, 1, 3);
        cycle(0, 1, 0, 0, 0);

        // Scan with a 3-cycle enable freeze while the second position is shown.
        cycle(0, 1, 1, 1, 2);
        for (int i = 0; i < 14; i++) cycle(0, (i < 2 || i > 4), 0, 0, 0);

        // Reset in the middle of a scan.
        cycle(0, 1, 1, 1, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(1, 1, 1, 1, 1);
        cycle(0, 1, 0, 0, 0);

        // Scan-mode request with code 5 (direct hold when scan is not built).
        cycle(0, 1, 1, 1, 5);
        for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0, 0);

        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) != 0),
                  $urandom_range(0, 1), $urandom_range(0, 1), int'($urandom_range(0, W - 1)));
        end

        @(negedge clk);
        #1;
        finished = 1'b1;
        if (passed != checks) begin
            $display("FAIL summary: %0d of %0d checks failed", checks - passed, checks);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
